qed_inst_filter: RTL

// - Parametrised, stateful instruction-constraint filter for SQED on picorv32: decodes every fetched RV32I word,

---
 rtl/qed_inst_filter.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/qed_inst_filter.sv
// SQED instruction-constraint filter: decodes and classifies RV32I words, tracks the SIF commit phase,
// meters the memory-op budget and keeps accept/reject statistics. Optional macro: QED_FORMAL_ASSUME_EN.
module qed_inst_filter #(
    parameter int unsigned REG_LIMIT   = 16,
    parameter int unsigned LD_IMM_MAX  = 64,
    parameter int unsigned ST_IMM7_MAX = 2,
    parameter int unsigned STORE_GUARD = 2,
    parameter int unsigned MEM_BUDGET  = 8,
    parameter int unsigned ALLOW_FENCE = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      instruction,
    input  logic             sif_commit,
    output logic             allowed,
    output logic [3:0]       inst_class,
    output logic [1:0]       phase,
    output logic [7:0]       mem_left,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] reject_cnt,
    output logic             violation
);

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_I       = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_LUI     = 4'd8,
        CLS_AUIPC   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_NOP     = 4'd11,
        CLS_FENCE   = 4'd12
    } inst_class_t;

    typedef enum logic [1:0] {
        PH_PRE  = 2'b00,
        PH_ARM  = 2'b01,
        PH_POST = 2'b10
    } phase_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_NOP    = 7'b1111111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [6:0]  FUNCT7_ALT  = 7'b0100000;
    localparam logic [7:0]  MEM_RESET   = 8'(MEM_BUDGET);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm12;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign imm12  = instruction[31:20];

    function automatic logic reg_ok(input logic [4:0] r);
        return 32'(r) < REG_LIMIT;
    endfunction

    logic rd_ok;
    logic rs1_ok;
    logic rs2_ok;
    logic ld_imm_ok;
    logic st_imm_ok;
    logic r_funct_ok;
    logic i_funct_ok;

    assign rd_ok     = reg_ok(rd);
    assign rs1_ok    = reg_ok(rs1);
    assign rs2_ok    = reg_ok(rs2);
    assign ld_imm_ok = (imm12[11:10] == 2'b00) && (32'(imm12) < LD_IMM_MAX);
    assign st_imm_ok = (funct7[6:5] == 2'b00) && (32'(funct7) < ST_IMM7_MAX);

    // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
    assign r_funct_ok = (funct7 == 7'b0) ||
                        ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        i_funct_ok = 1'b1;
        case (funct3)
            3'b001:  i_funct_ok = (funct7 == 7'b0);
            3'b101:  i_funct_ok = (funct7 == 7'b0) || (funct7 == FUNCT7_ALT);
            default: i_funct_ok = 1'b1;
        endcase
    end

    inst_class_t cls;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_R: begin
                if (r_funct_ok && rs1_ok && rs2_ok && rd_ok)
                    cls = CLS_R;
            end
            OP_I: begin
                if (i_funct_ok && rs1_ok && rd_ok)
                    cls = CLS_I;
            end
            OP_LOAD: begin
                if ((funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) &&
                    (rs1 == 5'd0) && rd_ok && ld_imm_ok)
                    cls = CLS_LOAD;
            end
            OP_STORE: begin
                if ((funct3 inside {3'b000, 3'b001, 3'b010}) &&
                    (rs1 == 5'd0) && rs2_ok && st_imm_ok)
                    cls = CLS_STORE;
            end
            OP_BRANCH: begin
                if ((funct3 != 3'b010) && (funct3 != 3'b011) && rs1_ok && rs2_ok)
                    cls = CLS_BRANCH;
            end
            OP_JAL: begin
                if (rd == 5'd0)
                    cls = CLS_JAL;
            end
            OP_JALR: begin
                if ((funct3 == 3'b000) && (rd == 5'd0) && rs1_ok)
                    cls = CLS_JALR;
            end
            OP_LUI: begin
                if (rd_ok)
                    cls = CLS_LUI;
            end
            OP_AUIPC: begin
                if (rd == 5'd0)
                    cls = CLS_AUIPC;
            end
            OP_SYSTEM: begin
                if ((instruction == ECALL_WORD) || (instruction == EBREAK_WORD))
                    cls = CLS_SYSTEM;
            end
            OP_NOP: begin
                cls = CLS_NOP;
            end
            OP_FENCE: begin
                if ((funct3 == 3'b000) && rs1_ok && rd_ok)
                    cls = CLS_FENCE;
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

    phase_t      phase_q;
    logic [7:0]  guard_cnt;
    logic [7:0]  mem_cnt;
    logic        mem_op;
    logic        budget_exhausted;
    logic        fence_en;

    assign mem_op           = (cls == CLS_LOAD) || (cls == CLS_STORE);
    assign budget_exhausted = (MEM_BUDGET != 0) && (mem_cnt == 8'd0);
    assign fence_en         = (ALLOW_FENCE != 0);

    assign allowed = (cls != CLS_ILLEGAL) &&
                     !((cls == CLS_STORE) && (phase_q != PH_POST)) &&
                     !((cls == CLS_FENCE) && !fence_en) &&
                     !(mem_op && budget_exhausted);

    assign inst_class = cls;
    assign phase      = phase_q;
    assign mem_left   = (MEM_BUDGET == 0) ? 8'hFF : mem_cnt;

    // Stores open up only after sif_commit has been held through STORE_GUARD cycles in ARM;
    // any drop of sif_commit sends the phase back to PRE.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_PRE;
            guard_cnt <= 8'd0;
        end else begin
            case (phase_q)
                PH_PRE: begin
                    if (sif_commit) begin
                        phase_q   <= PH_ARM;
                        guard_cnt <= 8'd1;
                    end
                end
                PH_ARM: begin
                    if (!sif_commit) begin
                        phase_q   <= PH_PRE;
                        guard_cnt <= 8'd0;
                    end else if (32'(guard_cnt) >= STORE_GUARD) begin
                        phase_q <= PH_POST;
                    end else begin
                        guard_cnt <= guard_cnt + 8'd1;
                    end
                end
                PH_POST: begin
                    if (!sif_commit) begin
                        phase_q   <= PH_PRE;
                        guard_cnt <= 8'd0;
                    end
                end
                default: begin
                    phase_q   <= PH_PRE;
                    guard_cnt <= 8'd0;
                end
            endcase
        end
    end

    // allowed already excludes an exhausted budget, so mem_cnt never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt    <= MEM_RESET;
            accept_cnt <= '0;
            reject_cnt <= '0;
            violation  <= 1'b0;
        end else if (inst_valid) begin
            if (allowed) begin
                if (accept_cnt != CNT_MAX)
                    accept_cnt <= accept_cnt + 1'b1;
                if (mem_op && (MEM_BUDGET != 0))
                    mem_cnt <= mem_cnt - 8'd1;
            end else begin
                if (reject_cnt != CNT_MAX)
                    reject_cnt <= reject_cnt + 1'b1;
                violation <= 1'b1;
            end
        end
    end

`ifdef QED_FORMAL_ASSUME_EN
    inst_legal_assume: assume property (@(posedge clk) disable iff (rst) inst_valid |-> allowed);
`else
    // Pure monitor: the instruction stream is left unconstrained.
`endif

endmodule
